// File: rtl/fwd_hazard_scheduler.sv
// rtl/fwd_hazard_scheduler.sv - issue-stage shadow pipeline driving forwarding taps and decode stall
// Optional stall/flush statistics counters enabled by defining FWD_STALL_STATS_EN.
module fwd_hazard_scheduler #(
  parameter int DEPTH = 6,
  parameter int REG_W = 3,
  parameter int STG_W = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   dec_valid_in,
  output logic                   dec_ready_out,
  input  logic [REG_W-1:0]       src_a_num_in,
  input  logic                   src_a_use_in,
  input  logic [REG_W-1:0]       src_b_num_in,
  input  logic                   src_b_use_in,
  input  logic [REG_W-1:0]       dst_num_in,
  input  logic                   dst_write_in,
  input  logic [STG_W-1:0]       rdy_stage_in,
  input  logic                   flush_in,
  input  logic [STG_W-1:0]       flush_depth_in,
  output logic                   stall_out,
  output logic [DEPTH*REG_W-1:0] fwd_num_out,
  output logic [DEPTH-1:0]       fwd_write_out,
  output logic [DEPTH-1:0]       fwd_ready_out,
  output logic                   issue_valid_out
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [15:0]            stall_cnt_out,
  output logic [15:0]            flush_cnt_out
`endif
);

  // Array index i holds slot i+1 (the instruction issued i+1 cycles ago).
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] we_q, we_d;
  logic [REG_W-1:0] dst_q [DEPTH];
  logic [REG_W-1:0] dst_d [DEPTH];
  logic [STG_W-1:0] rdy_q [DEPTH];
  logic [STG_W-1:0] rdy_d [DEPTH];

  logic             haz_a, haz_b, fire;
  logic [STG_W-1:0] rdy_sat;

  // The youngest writer of src wins (same priority as the forwarding mux);
  // it is a hazard while that writer is still younger than its ready stage.
  function automatic logic src_hazard(input logic [REG_W-1:0] src);
    logic found;
    logic haz;
    found = 1'b0;
    haz   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && we_q[i] && (dst_q[i] == src)) begin
        found = 1'b1;
        haz   = ((i + 1) < int'(rdy_q[i]));
      end
    end
    return haz;
  endfunction

  // Hazard detection, handshake and ready-stage saturation.
  always_comb begin
    haz_a         = src_a_use_in && src_hazard(src_a_num_in);
    haz_b         = src_b_use_in && src_hazard(src_b_num_in);
    stall_out     = rst_n_in && dec_valid_in && (haz_a || haz_b) && !flush_in;
    dec_ready_out = rst_n_in && !stall_out;
    fire          = dec_valid_in && dec_ready_out;
    if (rdy_stage_in == '0) begin
      rdy_sat = STG_W'(1);
    end else if (int'(rdy_stage_in) > DEPTH) begin
      rdy_sat = STG_W'(DEPTH);
    end else begin
      rdy_sat = rdy_stage_in;
    end
  end

  // Next shadow-pipeline contents: kill flushed slots, shift by one, insert issue or bubble.
  always_comb begin
    valid_d = '0;
    we_d    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dst_d[i] = '0;
      rdy_d[i] = STG_W'(1);
    end
    if (fire && !flush_in) begin
      valid_d[0] = 1'b1;
      we_d[0]    = dst_write_in;
      dst_d[0]   = dst_num_in;
      rdy_d[0]   = rdy_sat;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (!(flush_in && (i <= int'(flush_depth_in)))) begin
        valid_d[i] = valid_q[i-1];
        we_d[i]    = we_q[i-1];
        dst_d[i]   = dst_q[i-1];
        rdy_d[i]   = rdy_q[i-1];
      end
    end
  end

  // Slot registers; reset leaves every slot empty and already ready.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      we_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i] <= '0;
        rdy_q[i] <= STG_W'(1);
      end
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i] <= dst_d[i];
        rdy_q[i] <= rdy_d[i];
      end
    end
  end

  // Forwarding-unit taps come straight from the slot registers.
  always_comb begin
    issue_valid_out = valid_q[0];
    fwd_write_out   = we_q;
    fwd_num_out     = '0;
    fwd_ready_out   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_num_out[(i+1)*REG_W-1 -: REG_W] = dst_q[i];
      fwd_ready_out[i] = we_q[i] && ((i + 1) >= int'(rdy_q[i]));
    end
  end

`ifdef FWD_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating increments for the statistics counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_out && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_in && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Statistics counter registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
  assign flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_scheduler.sv
// tb/tb_fwd_hazard_scheduler.sv - vector-table bench for fwd_hazard_scheduler
module tb_fwd_hazard_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, dec_valid, dec_ready;
  logic [2:0]  src_a, src_b, dst, rdy, fdepth;
  logic        use_a, use_b, dst_we, flush, stall, iv;
  logic [17:0] fnum;
  logic [5:0]  fwrite, fready;
`ifdef FWD_STALL_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_scheduler dut (
    .clk_in(clk), .rst_n_in(rst_n), .dec_valid_in(dec_valid), .dec_ready_out(dec_ready),
    .src_a_num_in(src_a), .src_a_use_in(use_a), .src_b_num_in(src_b), .src_b_use_in(use_b),
    .dst_num_in(dst), .dst_write_in(dst_we), .rdy_stage_in(rdy), .flush_in(flush),
    .flush_depth_in(fdepth), .stall_out(stall), .fwd_num_out(fnum), .fwd_write_out(fwrite),
    .fwd_ready_out(fready), .issue_valid_out(iv)
`ifdef FWD_STALL_STATS_EN
    , .stall_cnt_out(stall_cnt), .flush_cnt_out(flush_cnt)
`endif
  );

  typedef struct {
    logic       rst, val;
    logic [2:0] a;  logic ua;
    logic [2:0] b;  logic ub;
    logic [2:0] d;  logic w;
    logic [2:0] r;  logic fl;
    logic [2:0] fd;
    logic       e_stall, e_ready;
    logic [5:0] e_write, e_fready;
    logic       e_iv;
    int         e_num;   // expected slot-1 dst, -1 = not checked
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t v(input int rst, val, a, ua, b, ub, d, w, r, fl, fd,
                             input int es, er, input logic [5:0] ew, ef, input int e_iv, num);
    vec_t t;
    t.rst = rst[0]; t.val = val[0]; t.a = 3'(a); t.ua = ua[0]; t.b = 3'(b); t.ub = ub[0];
    t.d = 3'(d); t.w = w[0]; t.r = 3'(r); t.fl = fl[0]; t.fd = 3'(fd);
    t.e_stall = es[0]; t.e_ready = er[0]; t.e_write = ew; t.e_fready = ef;
    t.e_iv = e_iv[0]; t.e_num = num;
    return t;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic r_n, val, input logic [2:0] a, input logic ua, input logic [2:0] b,
                       input logic ub, input logic [2:0] d, input logic w, input logic [2:0] r,
                       input logic fl, input logic [2:0] fd);
    rst_n = r_n; dec_valid = val; src_a = a; use_a = ua; src_b = b; use_b = ub;
    dst = d; dst_we = w; rdy = r; flush = fl; fdepth = fd;
  endtask

  initial begin
    int cnt;
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 3'd0);

    // rst val a ua b ub d w r fl fd | stall ready | write fready iv num
    tbl[0]  = v(0,1, 1,1, 0,0, 1,1,1, 0,0, 0,0, 6'b000000,6'b000000,0, 0);
    tbl[1]  = v(1,0, 0,0, 0,0, 0,0,1, 0,0, 0,1, 6'b000000,6'b000000,0,-1);
    tbl[2]  = v(1,1, 0,0, 0,0, 1,1,1, 0,0, 0,1, 6'b000001,6'b000001,1, 1);
    tbl[3]  = v(1,1, 1,1, 0,0, 5,1,1, 0,0, 0,1, 6'b000011,6'b000011,1, 5);
    tbl[4]  = v(1,1, 0,0, 0,0, 2,1,3, 0,0, 0,1, 6'b000111,6'b000110,1, 2);
    tbl[5]  = v(1,1, 0,0, 2,1, 6,1,1, 0,0, 1,0, 6'b001110,6'b001100,0,-1);
    tbl[6]  = v(1,1, 0,0, 2,1, 6,1,1, 0,0, 1,0, 6'b011100,6'b011100,0,-1);
    tbl[7]  = v(1,1, 0,0, 2,1, 6,1,1, 0,0, 0,1, 6'b111001,6'b111001,1, 6);
    tbl[8]  = v(1,1, 0,0, 0,0, 3,1,4, 0,0, 0,1, 6'b110011,6'b110010,1, 3);
    tbl[9]  = v(1,1, 0,0, 0,0, 3,1,1, 0,0, 0,1, 6'b100111,6'b100101,1, 3);
    tbl[10] = v(1,1, 3,1, 0,0, 0,0,1, 0,0, 0,1, 6'b001110,6'b001010,1, 0);
    tbl[11] = v(1,1, 0,0, 0,0, 4,1,3, 0,0, 0,1, 6'b011101,6'b011100,1, 4);
    tbl[12] = v(1,1, 4,1, 0,0, 7,1,1, 1,1, 0,1, 6'b111000,6'b111000,0,-1);
    tbl[13] = v(1,1, 4,1, 0,0, 7,1,1, 0,0, 0,1, 6'b110001,6'b110001,1, 7);
    tbl[14] = v(1,1, 0,0, 0,0, 2,1,3, 0,0, 0,1, 6'b100011,6'b100010,1, 2);
    tbl[15] = v(1,1, 2,1, 0,0, 5,1,1, 0,0, 1,0, 6'b000110,6'b000100,0,-1);
    tbl[16] = v(0,1, 2,1, 0,0, 5,1,1, 0,0, 0,0, 6'b000000,6'b000000,0, 0);
    tbl[17] = v(1,1, 2,1, 0,0, 5,1,1, 0,0, 0,1, 6'b000001,6'b000001,1, 5);
    tbl[18] = v(1,1, 0,0, 0,0, 2,1,3, 0,0, 0,1, 6'b000011,6'b000010,1, 2);
    tbl[19] = v(1,1, 2,0, 2,0, 0,0,0, 0,0, 0,1, 6'b000110,6'b000100,1, 0);
    tbl[20] = v(1,1, 2,1, 2,1, 1,1,7, 0,0, 1,0, 6'b001100,6'b001100,0,-1);
    tbl[21] = v(1,1, 2,1, 2,1, 1,1,7, 0,0, 0,1, 6'b011001,6'b011000,1, 1);
    tbl[22] = v(1,0, 0,0, 0,0, 0,0,1, 0,0, 0,1, 6'b110010,6'b110000,0,-1);
    tbl[23] = v(1,0, 0,0, 0,0, 0,0,1, 0,0, 0,1, 6'b100100,6'b100000,0,-1);
    tbl[24] = v(1,0, 0,0, 0,0, 0,0,1, 0,0, 0,1, 6'b001000,6'b000000,0,-1);
    tbl[25] = v(1,0, 0,0, 0,0, 0,0,1, 0,0, 0,1, 6'b010000,6'b000000,0,-1);
    tbl[26] = v(1,0, 0,0, 0,0, 0,0,1, 0,0, 0,1, 6'b100000,6'b100000,0,-1);
    tbl[27] = v(1,1, 0,0, 0,0, 3,1,1, 0,0, 0,1, 6'b000001,6'b000001,1, 3);
    tbl[28] = v(1,1, 0,0, 0,0, 4,1,1, 0,0, 0,1, 6'b000011,6'b000011,1, 4);
    tbl[29] = v(1,0, 0,0, 0,0, 0,0,1, 1,7, 0,1, 6'b000000,6'b000000,0,-1);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].val, tbl[i].a, tbl[i].ua, tbl[i].b, tbl[i].ub,
            tbl[i].d, tbl[i].w, tbl[i].r, tbl[i].fl, tbl[i].fd);
      #1;
      chk("stall_out", i, 32'(stall), 32'(tbl[i].e_stall));
      chk("dec_ready_out", i, 32'(dec_ready), 32'(tbl[i].e_ready));
      @(posedge clk);
      #1;
      chk("fwd_write_out", i, 32'(fwrite), 32'(tbl[i].e_write));
      chk("fwd_ready_out", i, 32'(fready), 32'(tbl[i].e_fready));
      chk("issue_valid_out", i, 32'(iv), 32'(tbl[i].e_iv));
      if (tbl[i].e_num >= 0) chk("fwd_num_slot1", i, 32'(fnum[2:0]), 32'(tbl[i].e_num));
    end

    // Producer with ready stage 5: dependent must stall exactly 4 cycles.
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 3'd5, 1'b0, 3'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 3'd0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (dec_ready) break;
      cnt++;
      @(negedge clk);
    end
    chk("rdy5_stall_cycles", 100, 32'(cnt), 32'd4);
    chk("rdy5_fwd_ready_slot5", 100, 32'(fready[4]), 32'd1);
    chk("rdy5_fwd_num_slot5", 100, 32'(fnum[14:12]), 32'd6);

`ifdef FWD_STALL_STATS_EN
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 3'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 3'd1);
    repeat (3) @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 3'd0);
    #1;
    chk("flush_cnt_out", 200, 32'(flush_cnt), 32'd3);
    chk("stall_cnt_after_reset", 200, 32'(stall_cnt), 32'd0);
    // Self-dependent slow producers: 5 stall cycles out of every 6.
    drive(1'b1, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 3'd6, 1'b0, 3'd0);
    cnt = 0;
    for (int k = 0; k < 90000 && cnt < 65600; k++) begin
      @(negedge clk);
      #1;
      if (stall) cnt++;
    end
    chk("stall_marathon_done", 201, 32'(cnt), 32'd65600);
    chk("stall_cnt_saturated", 201, 32'(stall_cnt), 32'hFFFF);
    repeat (12) @(negedge clk);
    chk("stall_cnt_held", 202, 32'(stall_cnt), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_scheduler.md
Name: fwd_hazard_scheduler

Overview:
- Issue-stage scheduler that tracks in-flight instructions in a DEPTH-slot shadow pipeline.
- Drives the forwarding unit's per-stage write-regnum and write-enable inputs (num_mK, mK_write).
- Stalls decode when a source register's producer has not yet reached the stage where its result is on a forwarding bus.
- Handles pipeline flush, and inserts bubbles on stall or flush.

Parameters:
- DEPTH, 6, number of tracked in-flight slots; slot k holds the instruction issued k cycles ago. Matches forwarding taps m1..m6.
- REG_W, 3, register-number width (8 architectural registers).
- STG_W, 3, width of the ready-stage field.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  synchronous active-low reset
- dec_valid_in  in  1  decode presents an instruction
- dec_ready_out  out  1  instruction accepted this cycle (issue fire = valid & ready)
- src_a_num_in  in  REG_W  source A register
- src_a_use_in  in  1  source A is read
- src_b_num_in  in  REG_W  source B register
- src_b_use_in  in  1  source B is read
- dst_num_in  in  REG_W  destination register
- dst_write_in  in  1  instruction writes dst
- rdy_stage_in  in  STG_W  slot index at which the result is first valid on a forwarding bus (ALU=1, load=3)
- flush_in  in  1  kill the youngest instructions
- flush_depth_in  in  STG_W  number of youngest slots to kill (0 = decode instruction only)
- stall_out  out  1  data hazard detected this cycle
- fwd_num_out  out  DEPTH*REG_W  slot k dst at bits [k*REG_W-1 -: REG_W]; feeds num_mK
- fwd_write_out  out  DEPTH  slot k write-enable; feeds mK_write
- fwd_ready_out  out  DEPTH  slot k write-enable && k >= slot rdy_stage
- issue_valid_out  out  1  slot 1 holds a real (non-bubble) instruction

Behaviour:
- State per slot: valid, we, dst, rdy.
- Reset (rst_n_in=0 at clk edge):
  - all slots valid=0, we=0, dst=0, rdy=1.
  - While rst_n_in=0, dec_ready_out=0 and stall_out=0.
  - Registered outputs are 0 in the cycle after reset.
- Hazard detection, per used source, combinational in the same cycle:
  - Select the lowest k (youngest) with slot k we=1 and dst==src. Older matches are ignored, matching the forwarding unit's priority.
  - Hazard if selected k < rdy of that slot.
  - No match means the value comes from the register file: no hazard.
  - stall_out = dec_valid_in && (hazA || hazB) && !flush_in.
- dec_ready_out:
  - 1 when rst_n_in && !stall_out, including the flush cycle.
  - On a flush cycle the decode instruction is discarded, not issued.
- Shift on every clock edge:
  - slot k+1 <= slot k; slot DEPTH retires (value now in register file).
  - slot 1 <= incoming instruction if fire && !flush_in, else a bubble (valid=0, we=0).
  - The stored rdy value is saturated to the range 1..DEPTH.
- Stall latency:
  - A producer with rdy=R issued in cycle t makes a dependent instruction stall for cycles t+1..t+R-1.
  - The dependent instruction issues in cycle t+R.
  - ALU back-to-back: zero stall cycles.
- Flush:
  - Before the shift, slots 1..n (n = min(flush_depth_in, DEPTH)) are cleared (valid=0, we=0).
  - After the shift, slots 2..n+1 are bubbles and slot 1 is a bubble.
  - Flush overrides stall.
- Simultaneous events:
  - Stall and flush in the same cycle: flush wins and no stall is reported.
  - Both sources hitting different slots: stall if either source has a hazard.
  - src_a==src_b: evaluated identically.
- Unused sources (use=0) never stall.
- dst_write_in=0 instructions occupy a slot as valid with we=0.
- Reset mid-stall: all slots clear. The next cycle after release has no hazard.
- fwd_* and issue_valid_out are driven directly from slot registers (no combinational path from inputs).

Optional Feature:
- Macro: FWD_STALL_STATS_EN.
- When defined:
  - Adds port stall_cnt_out out 16: saturating counter of cycles with stall_out=1.
  - Adds port flush_cnt_out out 16: saturating count of flush_in cycles.
  - Both counters reset to 0 and hold at 16'hFFFF.
- When undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- ALU chain:
  - Cycle 0: issue dst=R1, rdy=1.
  - Cycle 1: issue src_a=R1 -> stall_out=0, fwd_num slot1=1, fwd_ready[1]=1.
- Load-use:
  - Issue dst=R2, rdy=3, then src_b=R2 -> stall_out=1 for 2 cycles with slot1 bubbles.
  - Issue on the 3rd cycle, with the producer in slot 3 and fwd_ready[3]=1.
- Shadowing:
  - slot2 we R3 rdy=4 (not ready) and slot1 we R3 rdy=1; decode src_a=R3 -> stall_out=0.
- Flush:
  - Load R4 rdy=3 in slot 1; dependent instruction on decode; flush_in=1, depth=1.
  - Response: dec_ready_out=1, dependent instruction discarded, next cycle slots 1–2 are bubbles, a re-presented dependent instruction issues with stall_out=0.
- Reset mid-stall:
  - Assert rst_n_in=0 during a load-use stall -> all fwd_write_out=0.
  - After release, the dependent instruction issues immediately.
- FWD_STALL_STATS_EN:
  - Force 70000 stall cycles -> stall_cnt_out=16'hFFFF, held.
  - Apply 3 flush cycles -> flush_cnt_out=3.
